// File: rtl/stf_generator.sv
// Transmit-side 802.11a L-STF source: streams NUM_REP 16-sample short-training periods
// as {I,Q} words over valid/ready, then pulses done. Optional macro: STF_GEN_WINDOW_EN.
module stf_generator #(
    parameter int NUM_REP    = 10,
    parameter int GAIN_SHIFT = 0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic        start,
    output logic [31:0] sample_out,
    output logic        sample_out_valid,
    input  logic        sample_out_ready,
    output logic        busy,
    output logic        done
);

    // Handshake: a sample moves on a rising edge where enable, sample_out_valid and
    // sample_out_ready are all high; while valid is high sample_out does not change.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] LAST_REP = 4'(NUM_REP - 1);

    state_t      state, state_n;
    logic [3:0]  idx, idx_n;
    logic [3:0]  rep, rep_n;
    logic [31:0] sample_q, sample_n;
    logic        valid_q, valid_n;
    logic        busy_q, busy_n;
    logic        done_q, done_n;
    logic        last_sample;
`ifdef STF_GEN_WINDOW_EN
    logic        tail, tail_n;
`endif

    // round(8192 * s_k) for the first 16 L-STF time-domain samples, {I,Q}
    function automatic logic [31:0] rom_word(input logic [3:0] k);
        logic signed [15:0] i, q;
        case (k)
            4'd0:    begin i =  16'sd377;  q =  16'sd377;  end
            4'd1:    begin i = -16'sd1081; q =  16'sd16;   end
            4'd2:    begin i = -16'sd106;  q = -16'sd647;  end
            4'd3:    begin i =  16'sd1171; q = -16'sd106;  end
            4'd4:    begin i =  16'sd754;  q =  16'sd0;    end
            4'd5:    begin i =  16'sd1171; q = -16'sd106;  end
            4'd6:    begin i = -16'sd106;  q = -16'sd647;  end
            4'd7:    begin i = -16'sd1081; q =  16'sd16;   end
            4'd8:    begin i =  16'sd377;  q =  16'sd377;  end
            4'd9:    begin i =  16'sd16;   q = -16'sd1081; end
            4'd10:   begin i = -16'sd647;  q = -16'sd106;  end
            4'd11:   begin i = -16'sd106;  q =  16'sd1171; end
            4'd12:   begin i =  16'sd0;    q =  16'sd754;  end
            4'd13:   begin i = -16'sd106;  q =  16'sd1171; end
            4'd14:   begin i = -16'sd647;  q = -16'sd106;  end
            default: begin i =  16'sd16;   q = -16'sd1081; end
        endcase
        return {i, q};
    endfunction

    function automatic logic [31:0] gained(input logic [3:0] k);
        logic [31:0]        w;
        logic signed [15:0] i, q;
        w = rom_word(k);
        i = $signed(w[31:16]) >>> GAIN_SHIFT;
        q = $signed(w[15:0]) >>> GAIN_SHIFT;
        return {i, q};
    endfunction

    // Transition-window half-amplitude version of a gained sample
    function automatic logic [31:0] halved(input logic [31:0] w);
        logic signed [15:0] i, q;
        i = $signed(w[31:16]) >>> 1;
        q = $signed(w[15:0]) >>> 1;
        return {i, q};
    endfunction

    assign last_sample = (idx == 4'd15) && (rep == LAST_REP);

    always_comb begin
        state_n  = state;
        idx_n    = idx;
        rep_n    = rep;
        sample_n = sample_q;
        valid_n  = valid_q;
        busy_n   = busy_q;
        done_n   = 1'b0;
`ifdef STF_GEN_WINDOW_EN
        tail_n   = tail;
`endif
        case (state)
            IDLE: begin
                valid_n = 1'b0;
                busy_n  = 1'b0;
                if (start) begin
                    state_n  = RUN;
                    idx_n    = 4'd0;
                    rep_n    = 4'd0;
                    valid_n  = 1'b1;
                    busy_n   = 1'b1;
`ifdef STF_GEN_WINDOW_EN
                    tail_n   = 1'b0;
                    sample_n = halved(gained(4'd0));
`else
                    sample_n = gained(4'd0);
`endif
                end
            end
            RUN: begin
                if (valid_q && sample_out_ready) begin
`ifdef STF_GEN_WINDOW_EN
                    if (tail) begin
                        state_n = DONE;
                        valid_n = 1'b0;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                    end else if (last_sample) begin
                        tail_n   = 1'b1;
                        sample_n = halved(gained(4'd0));
                    end else begin
`else
                    if (last_sample) begin
                        state_n = DONE;
                        valid_n = 1'b0;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                    end else begin
`endif
                        idx_n    = idx + 4'd1;
                        sample_n = gained(idx + 4'd1);
                        if (idx == 4'd15) rep_n = rep + 4'd1;
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
                valid_n = 1'b0;
                busy_n  = 1'b0;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            idx      <= 4'd0;
            rep      <= 4'd0;
            sample_q <= 32'd0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef STF_GEN_WINDOW_EN
            tail     <= 1'b0;
`endif
        end else if (enable) begin
            state    <= state_n;
            idx      <= idx_n;
            rep      <= rep_n;
            sample_q <= sample_n;
            valid_q  <= valid_n;
            busy_q   <= busy_n;
            done_q   <= done_n;
`ifdef STF_GEN_WINDOW_EN
            tail     <= tail_n;
`endif
        end
    end

    assign sample_out       = sample_q;
    assign sample_out_valid = valid_q;
    assign busy             = busy_q;
    assign done             = done_q;

endmodule

// File: tb/tb_stf_generator.sv
// Directed bench for stf_generator: full bursts, stalls, ignored starts, mid-burst reset,
// clock-enable freeze and a GAIN_SHIFT=2 instance; honours STF_GEN_WINDOW_EN.
module tb_stf_generator;

    localparam int NUM_REP = 10;
`ifdef STF_GEN_WINDOW_EN
    localparam int BURST = 16 * NUM_REP + 1;
`else
    localparam int BURST = 16 * NUM_REP;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b1;
    logic        start = 1'b0;
    logic [31:0] sample_out;
    logic        sample_out_valid;
    logic        sample_out_ready = 1'b1;
    logic        busy;
    logic        done;

    logic        start2 = 1'b0;
    logic [31:0] sample2;
    logic        valid2, busy2, done2;

    int n_cmp = 0;
    int n_err = 0;

    // Hand-computed round(8192 * s_k) reference table
    int tab_i [16] = '{377, -1081, -106, 1171, 754, 1171, -106, -1081,
                       377, 16, -647, -106, 0, -106, -647, 16};
    int tab_q [16] = '{377, 16, -647, -106, 0, -106, -647, 16,
                       377, -1081, -106, 1171, 754, 1171, -106, -1081};

    stf_generator #(.NUM_REP(NUM_REP), .GAIN_SHIFT(0)) u_dut (
        .clock(clock), .reset(reset), .enable(enable), .start(start),
        .sample_out(sample_out), .sample_out_valid(sample_out_valid),
        .sample_out_ready(sample_out_ready), .busy(busy), .done(done)
    );

    stf_generator #(.NUM_REP(NUM_REP), .GAIN_SHIFT(2)) u_dut_g2 (
        .clock(clock), .reset(reset), .enable(1'b1), .start(start2),
        .sample_out(sample2), .sample_out_valid(valid2),
        .sample_out_ready(1'b1), .busy(busy2), .done(done2)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_word(input int n);
        int i, q;
        i = tab_i[n % 16];
        q = tab_q[n % 16];
`ifdef STF_GEN_WINDOW_EN
        if (n == 0 || n == 16 * NUM_REP) begin
            i = tab_i[0] >>> 1;
            q = tab_q[0] >>> 1;
        end
`endif
        return {i[15:0], q[15:0]};
    endfunction

    // Pulse start and confirm one-cycle latency to the first valid sample.
    task automatic kick;
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check_eq("start_valid", 32'(sample_out_valid), 32'd1);
        check_eq("start_busy", 32'(busy), 32'd1);
    endtask

    // mode 1: ready high; 2: random ready + enable freeze; 3: stray starts; 4: reset at 80
    task automatic run_burst(input int mode);
        int          count = 0;
        int          gap = 0;
        int          cycles = 0;
        int          en_hold = 0;
        bit          hit40 = 0;
        bit          xfer;
        bit          prev_stall = 0;
        logic [31:0] prev = '0;
        while (1) begin
            cycles++;
            gap++;
            if (prev_stall) begin
                check_eq("stall_hold", sample_out, prev);
                check_eq("stall_valid", 32'(sample_out_valid), 32'd1);
            end
            if (done) begin
                check_eq("done_len", 32'(count), 32'(BURST));
                check_eq("done_gap", 32'(gap), 32'd1);
                if (mode == 3) start = 1'b1;
                break;
            end
            if (cycles > 3000) begin
                check_eq("burst_timeout", 32'(count), 32'(BURST));
                break;
            end
            if (mode == 4 && count == 80) begin
                reset = 1'b1;
                break;
            end
            sample_out_ready = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
            if (mode == 2 && count == 5 && en_hold < 3) begin
                enable = 1'b0;
                en_hold++;
            end else begin
                enable = 1'b1;
            end
            if (mode == 3 && count == 40 && !hit40) begin
                start = 1'b1;
                hit40 = 1;
            end else begin
                start = 1'b0;
            end
            xfer = sample_out_valid && sample_out_ready && enable;
            if (xfer) begin
                check_eq($sformatf("sample_%0d", count), sample_out, exp_word(count));
                count++;
                gap = 0;
            end
            prev_stall = sample_out_valid && !xfer;
            prev = sample_out;
            @(negedge clock);
        end
        enable = 1'b1;
        sample_out_ready = 1'b1;
    endtask

    task automatic expect_idle(input string tag);
        check_eq({tag, "_valid"}, 32'(sample_out_valid), 32'd0);
        check_eq({tag, "_busy"}, 32'(busy), 32'd0);
        check_eq({tag, "_done"}, 32'(done), 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clock);
        check_eq("rst_sample", sample_out, 32'd0);
        expect_idle("rst");
        reset = 1'b0;
        @(negedge clock);
        expect_idle("idle");

        // 1: back-to-back burst
        kick();
        run_burst(1);
        @(negedge clock);
        expect_idle("t1_after");

        // 2: random backpressure and a three-cycle enable freeze
        kick();
        run_burst(2);
        @(negedge clock);
        expect_idle("t2_after");

        // 3: starts at sample 40 and during DONE must be ignored
        kick();
        run_burst(3);
        @(negedge clock);
        start = 1'b0;
        expect_idle("t3_done_start");
        @(negedge clock);
        expect_idle("t3_no_restart");

        // 4: reset mid-burst aborts without done, then a clean restart
        kick();
        run_burst(4);
        @(negedge clock);
        check_eq("t4_sample", sample_out, 32'd0);
        expect_idle("t4_abort");
        reset = 1'b0;
        repeat (2) begin
            @(negedge clock);
            expect_idle("t4_quiet");
        end
        kick();
        check_eq("t4_first", sample_out, exp_word(0));
        run_burst(1);

        // 5: GAIN_SHIFT=2 keeps sign through the shift
        @(negedge clock);
        start2 = 1'b1;
        @(negedge clock);
        start2 = 1'b0;
        check_eq("g2_valid", 32'(valid2), 32'd1);
`ifdef STF_GEN_WINDOW_EN
        check_eq("g2_s0", sample2, 32'h002F_002F);
`else
        check_eq("g2_s0", sample2, 32'h005E_005E);
`endif
        @(negedge clock);
        check_eq("g2_s1", sample2, 32'hFEF1_0004);
        @(negedge clock);
        check_eq("g2_s2", sample2, 32'hFFE5_FF5E);
        repeat (BURST) begin
            @(negedge clock);
            if (done2) break;
        end
        check_eq("g2_done", 32'(done2), 32'd1);
        @(negedge clock);
        check_eq("g2_idle", 32'(busy2), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
